// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch control: arbitrates instruction memory between the word-serial
// loader and normal fetch, then sequences FETCH/DECODE/EXEC with one PC write per retire.
module fetch_sequencer #(
   parameter int ADDR_W   = 10,
   parameter int IM_LAT   = 1,
   parameter int BUSY_MAX = 255
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              start,
   input  logic              ld_valid,
   input  logic [31:0]       ld_data,
   input  logic              ld_last,
   output logic              ld_ready,
   output logic              im_WE,
   output logic [31:0]       im_DATA,
   output logic              im_sel,
   output logic [ADDR_W-1:0] ld_addr,
   output logic              ld_wrap,
   output logic              ir_WE,
   input  logic              halt_instr,
   input  logic              ex_busy,
   output logic              uc_W_PC,
   output logic [31:0]       instr_cnt,
   output logic              running,
   output logic              halted,
   output logic              wd_err,
   output logic [2:0]        state
);

   localparam int LAT_W  = (IM_LAT > 1) ? $clog2(IM_LAT) : 1;
   localparam int BUSY_W = (BUSY_MAX > 1) ? $clog2(BUSY_MAX + 1) : 1;
   localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(IM_LAT - 1);
   localparam logic [BUSY_W-1:0] BUSY_LAST = BUSY_W'(BUSY_MAX - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_FETCH  = 3'd2,
      S_DECODE = 3'd3,
      S_EXEC   = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   ld_addr_q, ld_addr_d;
   logic                ld_wrap_q, ld_wrap_d;
   logic                wd_err_q, wd_err_d;
   logic [31:0]         instr_cnt_q, instr_cnt_d;
   logic [LAT_W-1:0]    lat_q, lat_d;
   logic [BUSY_W-1:0]   busy_q, busy_d;
   logic                accept;

   assign ld_ready  = (state_q == S_IDLE) || (state_q == S_LOAD) || (state_q == S_HALT);
   assign accept    = ld_valid & ld_ready;
   assign im_WE     = accept;
   assign im_DATA   = ld_data;
   assign im_sel    = ld_ready;
   // A burst always starts at address 0, so outside LOAD the next write address is 0.
   assign ld_addr   = (state_q == S_LOAD) ? ld_addr_q : '0;
   assign ld_wrap   = ld_wrap_q;
   assign wd_err    = wd_err_q;
   assign instr_cnt = instr_cnt_q;
   assign running   = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC);
   assign halted    = (state_q == S_HALT);
   assign state     = state_q;

   always_comb begin
      state_d     = state_q;
      ld_addr_d   = ld_addr_q;
      ld_wrap_d   = ld_wrap_q;
      wd_err_d    = wd_err_q;
      instr_cnt_d = instr_cnt_q;
      lat_d       = lat_q;
      busy_d      = busy_q;
      ir_WE       = 1'b0;
      uc_W_PC     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d   = S_LOAD;
               ld_addr_d = ADDR_W'(1);
               ld_wrap_d = 1'b0;
            end else if (start) begin
               state_d = S_FETCH;
               lat_d   = '0;
            end
         end
         S_LOAD: begin
            if (accept) begin
               ld_addr_d = ld_addr_q + ADDR_W'(1);
               if (&ld_addr_q) ld_wrap_d = 1'b1;
               if (ld_last) state_d = S_IDLE;
            end
         end
         S_FETCH: begin
            if (lat_q == LAT_LAST) state_d = S_DECODE;
            else lat_d = lat_q + LAT_W'(1);
         end
         S_DECODE: begin
            ir_WE   = 1'b1;
            busy_d  = '0;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            if (halt_instr) begin
               state_d = S_HALT;
            end else if (ex_busy) begin
               busy_d = busy_q + BUSY_W'(1);
               if (busy_q == BUSY_LAST) begin
                  state_d  = S_HALT;
                  wd_err_d = 1'b1;
               end
            end else begin
               uc_W_PC     = 1'b1;
               instr_cnt_d = instr_cnt_q + 32'd1;
               state_d     = S_FETCH;
               lat_d       = '0;
            end
         end
         S_HALT: begin
            if (accept) begin
               state_d   = S_LOAD;
               ld_addr_d = ADDR_W'(1);
               ld_wrap_d = 1'b0;
               wd_err_d  = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= S_IDLE;
         ld_addr_q   <= '0;
         ld_wrap_q   <= 1'b0;
         wd_err_q    <= 1'b0;
         instr_cnt_q <= '0;
         lat_q       <= '0;
         busy_q      <= '0;
      end else begin
         state_q     <= state_d;
         ld_addr_q   <= ld_addr_d;
         ld_wrap_q   <= ld_wrap_d;
         wd_err_q    <= wd_err_d;
         instr_cnt_q <= instr_cnt_d;
         lat_q       <= lat_d;
         busy_q      <= busy_d;
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: two instances (IM_LAT 1 and 3, ADDR_W 3, BUSY_MAX 8) share
// stimulus; a behavioural model checks every cycle, plus literal scenario checks.
module tb_fetch_sequencer;

   localparam int SIZE = 8;
   localparam int BMAX = 8;

   logic        clock = 1'b0;
   logic        rstN;
   logic        start, ldValid, ldLast, haltInstr, exBusy;
   logic [31:0] ldData;

   logic        ldReady[2], imWe[2], imSel[2], ldWrap[2], irWe[2], ucWPc[2];
   logic        running[2], halted[2], wdErr[2];
   logic [31:0] imData[2], instrCnt[2];
   logic [2:0]  ldAddr[2], stateO[2];

   int          assertCount = 0;
   int          failCount   = 0;
   int          ucCount[2]  = '{0, 0};

   int          latOf[2] = '{1, 3};
   int          mSt[2], mAddr[2], mWrap[2], mWd[2], mFetch[2], mBusy[2];
   logic [31:0] mCnt[2];

   always #5 clock = ~clock;

   fetch_sequencer #(.ADDR_W(3), .IM_LAT(1), .BUSY_MAX(BMAX)) u0 (
      .CLK(clock), .RST_N(rstN), .start(start), .ld_valid(ldValid), .ld_data(ldData),
      .ld_last(ldLast), .ld_ready(ldReady[0]), .im_WE(imWe[0]), .im_DATA(imData[0]),
      .im_sel(imSel[0]), .ld_addr(ldAddr[0]), .ld_wrap(ldWrap[0]), .ir_WE(irWe[0]),
      .halt_instr(haltInstr), .ex_busy(exBusy), .uc_W_PC(ucWPc[0]), .instr_cnt(instrCnt[0]),
      .running(running[0]), .halted(halted[0]), .wd_err(wdErr[0]), .state(stateO[0]));

   fetch_sequencer #(.ADDR_W(3), .IM_LAT(3), .BUSY_MAX(BMAX)) u1 (
      .CLK(clock), .RST_N(rstN), .start(start), .ld_valid(ldValid), .ld_data(ldData),
      .ld_last(ldLast), .ld_ready(ldReady[1]), .im_WE(imWe[1]), .im_DATA(imData[1]),
      .im_sel(imSel[1]), .ld_addr(ldAddr[1]), .ld_wrap(ldWrap[1]), .ir_WE(irWe[1]),
      .halt_instr(haltInstr), .ex_busy(exBusy), .uc_W_PC(ucWPc[1]), .instr_cnt(instrCnt[1]),
      .running(running[1]), .halted(halted[1]), .wd_err(wdErr[1]), .state(stateO[1]));

   task automatic checkOutput(input string name, input int unit, input logic [31:0] actual,
                              input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s unit%0d @%0t: got %0h expected %0h", name, unit, $time,
                  actual, expected);
      end
   endtask

   task automatic modelReset(input int u);
      mSt[u] = 0; mAddr[u] = 0; mWrap[u] = 0; mWd[u] = 0;
      mFetch[u] = 0; mBusy[u] = 0; mCnt[u] = '0;
   endtask

   // Effect of the coming rising edge on the spec-level model of one unit.
   task automatic modelStep(input int u);
      bit acc;
      acc = ldValid && (mSt[u] == 0 || mSt[u] == 1 || mSt[u] == 5);
      case (mSt[u])
         0: if (acc) begin
               mSt[u] = 1; mAddr[u] = 1; mWrap[u] = 0;
            end else if (start) begin
               mSt[u] = 2; mFetch[u] = latOf[u];
            end
         1: if (acc) begin
               if (mAddr[u] == SIZE - 1) mWrap[u] = 1;
               mAddr[u] = (mAddr[u] + 1) % SIZE;
               if (ldLast) mSt[u] = 0;
            end
         2: begin
               mFetch[u]--;
               if (mFetch[u] == 0) mSt[u] = 3;
            end
         3: begin
               mBusy[u] = 0; mSt[u] = 4;
            end
         4: if (haltInstr) begin
               mSt[u] = 5;
            end else if (exBusy) begin
               mBusy[u]++;
               if (mBusy[u] == BMAX) begin
                  mSt[u] = 5; mWd[u] = 1;
               end
            end else begin
               mCnt[u] = mCnt[u] + 32'd1; mSt[u] = 2; mFetch[u] = latOf[u];
            end
         5: if (acc) begin
               mSt[u] = 1; mAddr[u] = 1; mWrap[u] = 0; mWd[u] = 0;
            end
         default: mSt[u] = 0;
      endcase
   endtask

   always @(negedge clock) begin : compare
      bit rdy;
      for (int u = 0; u < 2; u++) begin
         if (!rstN) modelReset(u);
         rdy = (mSt[u] == 0 || mSt[u] == 1 || mSt[u] == 5);
         checkOutput("state", u, 32'(stateO[u]), mSt[u]);
         checkOutput("ld_ready", u, 32'(ldReady[u]), 32'(rdy));
         checkOutput("im_WE", u, 32'(imWe[u]), 32'(rdy && ldValid));
         checkOutput("im_sel", u, 32'(imSel[u]), 32'(rdy));
         checkOutput("im_DATA", u, imData[u], ldData);
         if (rdy) checkOutput("ld_addr", u, 32'(ldAddr[u]), (mSt[u] == 1) ? mAddr[u] : 0);
         checkOutput("ld_wrap", u, 32'(ldWrap[u]), mWrap[u]);
         checkOutput("ir_WE", u, 32'(irWe[u]), 32'(mSt[u] == 3));
         checkOutput("uc_W_PC", u, 32'(ucWPc[u]), 32'(mSt[u] == 4 && !haltInstr && !exBusy));
         checkOutput("instr_cnt", u, instrCnt[u], mCnt[u]);
         checkOutput("running", u, 32'(running[u]), 32'(mSt[u] >= 2 && mSt[u] <= 4));
         checkOutput("halted", u, 32'(halted[u]), 32'(mSt[u] == 5));
         checkOutput("wd_err", u, 32'(wdErr[u]), mWd[u]);
         if (ucWPc[u] === 1'b1) ucCount[u]++;
         if (rstN) modelStep(u);
      end
   end

   task automatic applyStimulus(input logic v, input logic last, input logic st,
                                input logic h, input logic b);
      ldValid = v; ldLast = last; start = st; haltInstr = h; exBusy = b;
      ldData = $urandom;
      @(posedge clock);
      #1;
   endtask

   task automatic loadBurst(input int n, input bit withLast);
      for (int i = 0; i < n; i++) begin
         ldValid = 1'b1; ldLast = withLast && (i == n - 1); ldData = $urandom;
         start = 1'b0; haltInstr = 1'b0; exBusy = 1'b0;
         #1;
         checkOutput("ldAddrSeq", 0, 32'(ldAddr[0]), i % SIZE);
         @(posedge clock);
         #1;
      end
      ldValid = 1'b0; ldLast = 1'b0;
   endtask

   task automatic pulseReset();
      #1 rstN = 1'b0;
      #1;
      checkOutput("rstState", 0, 32'(stateO[0]), 0);
      checkOutput("rstInstrCnt", 0, instrCnt[0], 0);
      checkOutput("rstRunning", 0, 32'(running[0]), 0);
      checkOutput("rstLdReady", 0, 32'(ldReady[0]), 1);
      @(posedge clock);
      #1 rstN = 1'b1;
   endtask

   initial begin
      int uc0;
      rstN = 1'b0; start = 1'b0; ldValid = 1'b0; ldLast = 1'b0;
      haltInstr = 1'b0; exBusy = 1'b0; ldData = '0;
      for (int u = 0; u < 2; u++) modelReset(u);
      repeat (2) @(posedge clock);
      #1;
      checkOutput("resetState", 0, 32'(stateO[0]), 0);
      checkOutput("resetImSel", 0, 32'(imSel[0]), 1);
      checkOutput("resetWdErr", 0, 32'(wdErr[0]), 0);
      rstN = 1'b1;

      // Load four words then run five instructions.
      loadBurst(4, 1);
      checkOutput("loadDoneState", 0, 32'(stateO[0]), 0);
      uc0 = ucCount[0];
      applyStimulus(0, 0, 1, 0, 0);
      repeat (15) applyStimulus(0, 0, 0, 0, 0);
      checkOutput("run15Cnt", 0, instrCnt[0], 5);
      checkOutput("run15Cnt", 1, instrCnt[1], 3);
      checkOutput("run15Pulses", 0, ucCount[0] - uc0, 5);

      // Second instruction stretched by four busy cycles.
      pulseReset();
      uc0 = ucCount[0];
      applyStimulus(0, 0, 1, 0, 0);
      for (int k = 1; k <= 10; k++) applyStimulus(0, 0, 0, 0, (k >= 6 && k <= 9));
      checkOutput("busyPulses", 0, ucCount[0] - uc0, 2);
      checkOutput("busyCnt", 0, instrCnt[0], 2);
      checkOutput("busyWd", 0, 32'(wdErr[0]), 0);
      checkOutput("busyState", 0, 32'(stateO[0]), 2);

      // Halt instruction, start ignored, reload from HALT.
      pulseReset();
      applyStimulus(0, 0, 1, 0, 0);
      for (int k = 1; k <= 5; k++) applyStimulus(0, 0, 0, (k >= 3), 0);
      checkOutput("haltHalted", 0, 32'(halted[0]), 1);
      checkOutput("haltCnt", 0, instrCnt[0], 0);
      checkOutput("haltState", 1, 32'(stateO[1]), 5);
      repeat (2) applyStimulus(0, 0, 1, 0, 0);
      checkOutput("haltIgnoresStart", 0, 32'(stateO[0]), 5);
      loadBurst(2, 1);
      checkOutput("haltReloadState", 0, 32'(stateO[0]), 0);

      // Watchdog with busy stuck high.
      pulseReset();
      applyStimulus(0, 0, 1, 0, 0);
      repeat (9) applyStimulus(0, 0, 0, 0, 1);
      checkOutput("wdBeforeState", 0, 32'(stateO[0]), 4);
      checkOutput("wdBeforeErr", 0, 32'(wdErr[0]), 0);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("wdState", 0, 32'(stateO[0]), 5);
      checkOutput("wdErr", 0, 32'(wdErr[0]), 1);
      repeat (4) applyStimulus(0, 0, 0, 0, 1);
      checkOutput("wdErr", 1, 32'(wdErr[1]), 1);
      loadBurst(2, 1);
      checkOutput("wdCleared", 0, 32'(wdErr[0]), 0);

      // Address wrap over ten words, then load/start contention.
      pulseReset();
      loadBurst(10, 1);
      checkOutput("wrapFlag", 0, 32'(ldWrap[0]), 1);
      applyStimulus(1, 0, 1, 0, 0);
      checkOutput("contentionState", 0, 32'(stateO[0]), 1);
      applyStimulus(1, 1, 0, 0, 0);
      checkOutput("contentionWrapCleared", 0, 32'(ldWrap[0]), 0);

      // Reset in the middle of a burst and of an EXEC busy wait.
      loadBurst(3, 0);
      pulseReset();
      loadBurst(3, 1);
      applyStimulus(0, 0, 1, 0, 0);
      repeat (6) applyStimulus(0, 0, 0, 0, 1);
      pulseReset();
      checkOutput("postResetCnt", 0, instrCnt[0], 0);

      // Randomized traffic with occasional resets.
      for (int c = 0; c < 2000; c++) begin
         if ($urandom_range(0, 249) == 0) begin
            pulseReset();
         end else begin
            applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                          $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                          $urandom_range(0, 1) == 0);
         end
      end
      applyStimulus(0, 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
